// File: rtl/icu_multiqueue_dispatcher.sv
// Instruction control unit front end: fetches words over a valid/ready
// handshake, decodes the unit nibble of the opcode and routes each unit
// instruction into one of NUM_QUEUES issue FIFOs. Supports NOP-with-repeat,
// HALT with drain detection and a sticky illegal-opcode flag.
//
// Handshakes: a transfer happens on a rising clk edge when valid && ready are
// both high in the preceding cycle. Valid never depends on ready on the
// producer side; q_instr/q_valid are registered and held while stalled.
module icu_multiqueue_dispatcher #(
  parameter int INSTR_WIDTH          = 32,
  parameter int INSTR_MEM_ADDR_WIDTH = 10,
  parameter int NUM_QUEUES           = 4,
  parameter int QUEUE_DEPTH          = 4,
  parameter int NOP_CNT_WIDTH        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0]     start_addr,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0]     instr_address,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  input  logic [INSTR_WIDTH-1:0]              instr_in,
  output logic [NUM_QUEUES-1:0]               q_valid,
  input  logic [NUM_QUEUES-1:0]               q_ready,
  output logic [NUM_QUEUES*INSTR_WIDTH-1:0]   q_instr,
  output logic                                busy,
  output logic                                done,
  output logic                                err_illegal
);

  localparam int AW    = INSTR_MEM_ADDR_WIDTH;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_NOP    = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            pc_q;
  logic [NOP_CNT_WIDTH-1:0] nop_cnt_q;
  logic                     err_q;

  // Decode fields
  logic [7:0]               op;
  logic [3:0]               unit_f;
  logic [3:0]               q_sel;
  logic [NOP_CNT_WIDTH-1:0] nop_n;
  logic                     is_nop, is_halt, is_unit, is_illegal;
  logic                     sel_full;
  logic                     hs;

  // Per-queue FIFO state
  logic [INSTR_WIDTH-1:0] mem    [NUM_QUEUES][QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr [NUM_QUEUES];
  logic [PTR_W-1:0]       rd_ptr [NUM_QUEUES];
  logic [CNT_W-1:0]       count  [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]  full;
  logic [NUM_QUEUES-1:0]  push;
  logic [NUM_QUEUES-1:0]  pop;

  assign op         = instr_in[31:24];
  assign unit_f     = op[7:4];
  assign q_sel      = unit_f - 4'd1;
  assign nop_n      = instr_in[NOP_CNT_WIDTH-1:0];
  assign is_nop     = (op == 8'h00);
  assign is_halt    = (op == 8'h0F);
  assign is_unit    = (unit_f != 4'd0) && (unit_f <= 4'(NUM_QUEUES));
  assign is_illegal = !is_nop && !is_halt && !is_unit;
  assign hs         = instr_valid && instr_ready;

  // Full flag of the queue the current word is addressed to
  always_comb begin
    sel_full = 1'b0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      if (q_sel == 4'(k)) sel_full = full[k];
    end
  end

  // Fetch ready: only unit words can be blocked, and only by their own queue
  always_comb begin
    instr_ready = 1'b0;
    if (state_q == S_RUN) instr_ready = is_unit ? !sel_full : 1'b1;
  end

  // Push strobes: the accepted unit word goes to exactly one queue
  always_comb begin
    push = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      push[k] = hs && is_unit && (q_sel == 4'(k));
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN: begin
        if (hs) begin
          if (is_halt)                                  state_d = S_HALTED;
          else if (is_nop && (nop_n != '0))             state_d = S_NOP;
        end
      end
      S_NOP:    if (nop_cnt_q == '0) state_d = S_RUN;
      S_HALTED: if (start) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register, program counter, NOP counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      nop_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc_q  <= start_addr;
            err_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (hs) begin
            pc_q <= pc_q + AW'(1);
            if (is_nop && (nop_n != '0)) nop_cnt_q <= nop_n - NOP_CNT_WIDTH'(1);
            if (is_illegal) err_q <= 1'b1;
          end
        end
        S_NOP: begin
          if (nop_cnt_q != '0) nop_cnt_q <= nop_cnt_q - NOP_CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy; reset empties every queue at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_QUEUES; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_QUEUES; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        if (push[k] && !pop[k])      count[k] <= count[k] + CNT_W'(1);
        else if (!push[k] && pop[k]) count[k] <= count[k] - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_QUEUES; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= instr_in;
    end
  end

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
    assign q_valid[g] = (count[g] != '0);
    assign full[g]    = (count[g] == CNT_W'(QUEUE_DEPTH));
    assign pop[g]     = q_valid[g] && q_ready[g];
    assign q_instr[g*INSTR_WIDTH +: INSTR_WIDTH] = mem[g][rd_ptr[g]];
  end

  assign instr_address = pc_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_NOP);
  assign done          = (state_q == S_HALTED) && (q_valid == '0);
  assign err_illegal   = err_q;

endmodule
